// File: rtl/riscv_mem_pkg.sv
// ============================================================================
// Module   : riscv_mem_pkg
// Brief    : Shared types for the iBus/dBus single-port memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_mem_pkg;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    typedef struct packed {
        owner_e owner;
        logic   is_write;
    } owner_ent_t;

endpackage

`default_nettype wire

// File: rtl/arb_owner_fifo.sv
// ============================================================================
// Module   : arb_owner_fifo
// Brief    : In-order ownership FIFO with wrap-around pointers and a count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_owner_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  T              din_i,
    input  logic          pop_i,
    output T              dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T              mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Round-robin iBus/dBus arbiter onto one valid/ready memory port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int OUTSTANDING = 2,
    parameter int AW          = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          iBus_cmd_valid,
    output logic          iBus_cmd_ready,
    input  logic [AW-1:0] iBus_cmd_payload_pc,
    output logic          iBus_rsp_ready,
    output logic [31:0]   iBus_rsp_instr,
    input  logic          dBus_cmd_valid,
    output logic          dBus_cmd_ready,
    input  logic [AW-1:0] dBus_cmd_payload_addr,
    input  logic [31:0]   dBus_cmd_payload_data,
    input  logic [3:0]    dBus_cmd_payload_size,
    input  logic          dBus_cmd_payload_wr,
    output logic          dBus_rsp_valid,
    output logic [31:0]   dBus_rsp_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [31:0]   m_data,
    output logic [3:0]    m_mask,
    input  logic          r_valid,
    input  logic [31:0]   r_data,
    output logic          rsp_orphan
);

    localparam int CW = $clog2(OUTSTANDING + 1);

    owner_e        last_q;
    owner_e        lock_sel_q;
    logic          locked_q;
    logic          orphan_q;
    owner_e        sel;
    logic          winner_valid;
    logic          accept;
    logic          sel_d;
    logic          rsp_hit;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    owner_ent_t    push_ent;
    owner_ent_t    head_ent;

    // A stalled grant keeps its port so the presented payload cannot switch mid-handshake.
    always_comb begin
        sel = OWN_I;
        if (locked_q) begin
            sel = lock_sel_q;
        end else if (iBus_cmd_valid && dBus_cmd_valid) begin
            sel = (last_q == OWN_I) ? OWN_D : OWN_I;
        end else if (dBus_cmd_valid) begin
            sel = OWN_D;
        end
    end

    assign sel_d          = (sel == OWN_D);
    assign winner_valid   = sel_d ? dBus_cmd_valid : iBus_cmd_valid;
    assign m_valid        = !rst && winner_valid && !fifo_full;
    assign accept         = m_valid && m_ready;
    assign iBus_cmd_ready = accept && !sel_d;
    assign dBus_cmd_ready = accept && sel_d;

    assign m_we   = m_valid && sel_d && dBus_cmd_payload_wr;
    assign m_addr = !m_valid ? '0 : (sel_d ? dBus_cmd_payload_addr : iBus_cmd_payload_pc);
    assign m_data = (m_valid && sel_d) ? dBus_cmd_payload_data : '0;
    assign m_mask = (m_valid && sel_d) ? dBus_cmd_payload_size : '0;

    assign push_ent = '{owner: sel, is_write: sel_d && dBus_cmd_payload_wr};

    arb_owner_fifo #(
        .DEPTH (OUTSTANDING),
        .T     (owner_ent_t)
    ) u_owner_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (accept),
        .din_i   (push_ent),
        .pop_i   (rsp_hit),
        .dout_o  (head_ent),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Write acknowledgements are popped like any response but never reach the bus.
    assign rsp_hit        = !rst && r_valid && !fifo_empty;
    assign iBus_rsp_ready = rsp_hit && (head_ent.owner == OWN_I);
    assign iBus_rsp_instr = iBus_rsp_ready ? r_data : '0;
    assign dBus_rsp_valid = rsp_hit && (head_ent.owner == OWN_D) && !head_ent.is_write;
    assign dBus_rsp_data  = dBus_rsp_valid ? r_data : '0;
    assign rsp_orphan     = orphan_q && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q     <= OWN_D;
            lock_sel_q <= OWN_I;
            locked_q   <= 1'b0;
            orphan_q   <= 1'b0;
        end else begin
            if (accept) begin
                last_q <= sel;
            end
            locked_q <= m_valid && !m_ready;
            if (m_valid && !m_ready) begin
                lock_sel_q <= sel;
            end
            if (r_valid && (fifo_count == '0)) begin
                orphan_q <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed bench with a queue-based reference model of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int OUT = 2;

    logic        clk;
    logic        rst;
    logic        iBus_cmd_valid;
    logic        iBus_cmd_ready;
    logic [31:0] iBus_cmd_payload_pc;
    logic        iBus_rsp_ready;
    logic [31:0] iBus_rsp_instr;
    logic        dBus_cmd_valid;
    logic        dBus_cmd_ready;
    logic [31:0] dBus_cmd_payload_addr;
    logic [31:0] dBus_cmd_payload_data;
    logic [3:0]  dBus_cmd_payload_size;
    logic        dBus_cmd_payload_wr;
    logic        dBus_rsp_valid;
    logic [31:0] dBus_rsp_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_data;
    logic [3:0]  m_mask;
    logic        r_valid;
    logic [31:0] r_data;
    logic        rsp_orphan;

    mem_port_arbiter #(.OUTSTANDING(OUT), .AW(32)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .iBus_cmd_valid        (iBus_cmd_valid),
        .iBus_cmd_ready        (iBus_cmd_ready),
        .iBus_cmd_payload_pc   (iBus_cmd_payload_pc),
        .iBus_rsp_ready        (iBus_rsp_ready),
        .iBus_rsp_instr        (iBus_rsp_instr),
        .dBus_cmd_valid        (dBus_cmd_valid),
        .dBus_cmd_ready        (dBus_cmd_ready),
        .dBus_cmd_payload_addr (dBus_cmd_payload_addr),
        .dBus_cmd_payload_data (dBus_cmd_payload_data),
        .dBus_cmd_payload_size (dBus_cmd_payload_size),
        .dBus_cmd_payload_wr   (dBus_cmd_payload_wr),
        .dBus_rsp_valid        (dBus_rsp_valid),
        .dBus_rsp_data         (dBus_rsp_data),
        .m_valid               (m_valid),
        .m_ready               (m_ready),
        .m_we                  (m_we),
        .m_addr                (m_addr),
        .m_data                (m_data),
        .m_mask                (m_mask),
        .r_valid               (r_valid),
        .r_data                (r_data),
        .rsp_orphan            (rsp_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int dpulses = 0;
    bit auto_rsp = 0;

    // Reference model: outstanding owners as a plain queue, previous winner, hold, orphan.
    typedef struct {
        bit is_d;
        bit wr;
    } ent_t;
    ent_t mq[$];
    bit   md_prev_d = 1'b1;
    bit   md_hold   = 1'b0;
    bit   md_hold_d = 1'b0;
    bit   md_orph   = 1'b0;

    bit          e_sel_d;
    logic        e_mv, e_we, e_irdy, e_drdy, e_irsp, e_drsp, e_orph;
    logic [31:0] e_addr, e_mdata, e_instr, e_ddata;
    logic [3:0]  e_mask;

    logic        s_mv, s_we, s_irdy, s_drdy, s_irsp, s_drsp, s_orph;
    logic [31:0] s_addr, s_mdata, s_instr, s_ddata;
    logic [3:0]  s_mask;

    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : {a[15:0], a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic eval();
        bit full;
        bit req;
        full = (mq.size() >= OUT);
        if (md_hold)                               e_sel_d = md_hold_d;
        else if (iBus_cmd_valid && dBus_cmd_valid) e_sel_d = !md_prev_d;
        else                                       e_sel_d = dBus_cmd_valid;
        req     = e_sel_d ? dBus_cmd_valid : iBus_cmd_valid;
        e_mv    = !rst && !full && req;
        e_we    = e_mv && e_sel_d && dBus_cmd_payload_wr;
        e_addr  = !e_mv ? 32'h0 : (e_sel_d ? dBus_cmd_payload_addr : iBus_cmd_payload_pc);
        e_mdata = (e_mv && e_sel_d) ? dBus_cmd_payload_data : 32'h0;
        e_mask  = (e_mv && e_sel_d) ? dBus_cmd_payload_size : 4'h0;
        e_irdy  = e_mv && m_ready && !e_sel_d;
        e_drdy  = e_mv && m_ready && e_sel_d;
        e_irsp  = 1'b0;
        e_drsp  = 1'b0;
        if (!rst && r_valid && mq.size() > 0) begin
            e_irsp = !mq[0].is_d;
            e_drsp = mq[0].is_d && !mq[0].wr;
        end
        e_instr = e_irsp ? r_data : 32'h0;
        e_ddata = e_drsp ? r_data : 32'h0;
        e_orph  = md_orph && !rst;
    endtask

    task automatic model_step();
        if (rst) begin
            mq.delete();
            md_prev_d = 1'b1;
            md_hold   = 1'b0;
            md_orph   = 1'b0;
        end else begin
            if (r_valid) begin
                if (mq.size() > 0) void'(mq.pop_front());
                else               md_orph = 1'b1;
            end
            if (e_mv && m_ready) begin
                mq.push_back('{is_d: e_sel_d, wr: e_sel_d && dBus_cmd_payload_wr});
                md_prev_d = e_sel_d;
            end
            md_hold   = e_mv && !m_ready;
            md_hold_d = e_sel_d;
        end
    endtask

    // One clock: sample and compare at negedge, advance model at posedge, then respond.
    task automatic tick();
        logic [31:0] w;
        @(negedge clk);
        eval();
        s_mv = m_valid;   s_we = m_we;     s_addr = m_addr;   s_mdata = m_data;
        s_mask = m_mask;  s_irdy = iBus_cmd_ready;  s_drdy = dBus_cmd_ready;
        s_irsp = iBus_rsp_ready;  s_instr = iBus_rsp_instr;
        s_drsp = dBus_rsp_valid;  s_ddata = dBus_rsp_data;  s_orph = rsp_orphan;
        if (s_drsp) dpulses++;
        chk("m_valid", {31'b0, s_mv}, {31'b0, e_mv});
        chk("m_we", {31'b0, s_we}, {31'b0, e_we});
        chk("m_addr", s_addr, e_addr);
        chk("m_data", s_mdata, e_mdata);
        chk("m_mask", {28'b0, s_mask}, {28'b0, e_mask});
        chk("iBus_cmd_ready", {31'b0, s_irdy}, {31'b0, e_irdy});
        chk("dBus_cmd_ready", {31'b0, s_drdy}, {31'b0, e_drdy});
        chk("iBus_rsp_ready", {31'b0, s_irsp}, {31'b0, e_irsp});
        chk("iBus_rsp_instr", s_instr, e_instr);
        chk("dBus_rsp_valid", {31'b0, s_drsp}, {31'b0, e_drsp});
        chk("dBus_rsp_data", s_ddata, e_ddata);
        chk("rsp_orphan", {31'b0, s_orph}, {31'b0, e_orph});
        @(posedge clk);
        model_step();
        #1;
        if (auto_rsp) begin
            if (s_mv && m_ready) begin
                r_valid = 1'b1;
                if (s_we) begin
                    w = rd(s_addr);
                    for (int b = 0; b < 4; b++)
                        if (s_mask[b]) w[8*b +: 8] = s_mdata[8*b +: 8];
                    mem[s_addr] = w;
                    r_data = 32'hFFFF_FFFF;
                end else begin
                    r_data = rd(s_addr);
                end
            end else begin
                r_valid = 1'b0;
                r_data  = 32'h0;
            end
        end
    endtask

    task automatic idle_inputs();
        iBus_cmd_valid = 0; iBus_cmd_payload_pc = 0;
        dBus_cmd_valid = 0; dBus_cmd_payload_addr = 0; dBus_cmd_payload_data = 0;
        dBus_cmd_payload_size = 0; dBus_cmd_payload_wr = 0;
    endtask

    task automatic do_reset();
        rst = 1; idle_inputs(); m_ready = 0;
        tick(); tick();
        rst = 0;
    endtask

    initial begin
        r_valid = 0; r_data = 0;
        do_reset();
        chk("rst_mvalid", {31'b0, s_mv}, 32'h0);
        chk("rst_orphan", {31'b0, s_orph}, 32'h0);
        m_ready = 1;
        tick();
        chk("idle_dready", {31'b0, s_drdy}, 32'h0);

        // Alternation: I first, then D, each receiving its own read data.
        auto_rsp = 1;
        iBus_cmd_valid = 1; iBus_cmd_payload_pc = 32'h100;
        dBus_cmd_valid = 1; dBus_cmd_payload_addr = 32'h200; dBus_cmd_payload_size = 4'hF;
        tick(); chk("alt1_addr", s_addr, 32'h100);
        tick(); chk("alt2_addr", s_addr, 32'h200); chk("alt2_instr", s_instr, 32'h0100_0100);
        tick(); chk("alt3_addr", s_addr, 32'h100); chk("alt3_ddata", s_ddata, 32'h0200_0200);
        tick();
        idle_inputs(); tick(); tick();

        // Lock: make I the last winner so the D write wins the tie, then stall it.
        do_reset();
        m_ready = 1; iBus_cmd_valid = 1; iBus_cmd_payload_pc = 32'h100;
        tick();
        m_ready = 0;
        dBus_cmd_valid = 1; dBus_cmd_payload_wr = 1; dBus_cmd_payload_addr = 32'h40;
        dBus_cmd_payload_data = 32'hDEAD_BEEF; dBus_cmd_payload_size = 4'hF;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("lock_addr", s_addr, 32'h40);
            chk("lock_data", s_mdata, 32'hDEAD_BEEF);
        end
        m_ready = 1;
        tick(); chk("lock_acc_drdy", {31'b0, s_drdy}, 32'h1); chk("lock_acc_we", {31'b0, s_we}, 32'h1);

        // Write suppression: the write ack is silent, the read back returns the written word.
        dBus_cmd_payload_wr = 0; dBus_cmd_payload_data = 0; dpulses = 0;
        tick(); chk("post_lock_igrant", s_addr, 32'h100); chk("wr_rsp_silent", {31'b0, s_drsp}, 32'h0);
        tick(); chk("rd40_addr", s_addr, 32'h40);
        idle_inputs();
        tick(); chk("rd40_data", s_ddata, 32'hDEAD_BEEF);
        tick(); chk("d_pulse_count", dpulses, 32'd1);

        // FIFO full with no responses; a pop does not open a same-cycle slot.
        do_reset();
        auto_rsp = 0; r_valid = 0; m_ready = 1;
        iBus_cmd_valid = 1; iBus_cmd_payload_pc = 32'h300;
        tick(); chk("full_acc1", {31'b0, s_irdy}, 32'h1);
        tick(); chk("full_acc2", {31'b0, s_irdy}, 32'h1);
        tick(); chk("full_irdy", {31'b0, s_irdy}, 32'h0); chk("full_mvalid", {31'b0, s_mv}, 32'h0);
        r_valid = 1; r_data = 32'h33;
        tick(); chk("full_pop_mvalid", {31'b0, s_mv}, 32'h0); chk("full_pop_instr", s_instr, 32'h33);
        r_valid = 0;
        tick(); chk("after_pop_irdy", {31'b0, s_irdy}, 32'h1);

        // Reset with two outstanding, then a late response is an orphan.
        rst = 1; dBus_cmd_valid = 1; dBus_cmd_payload_addr = 32'h600; iBus_cmd_payload_pc = 32'h500;
        tick(); chk("rst_busy_mvalid", {31'b0, s_mv}, 32'h0);
        rst = 0; r_valid = 1; r_data = 32'h77;
        tick(); chk("post_rst_tie", s_addr, 32'h500); chk("late_rsp_silent", {31'b0, s_irsp}, 32'h0);
        r_valid = 0; idle_inputs();
        tick(); chk("orphan_set", {31'b0, s_orph}, 32'h1);
        tick(); chk("orphan_sticky", {31'b0, s_orph}, 32'h1);
        rst = 1;
        tick(); chk("orphan_rst", {31'b0, s_orph}, 32'h0);
        rst = 0;

        // Orphan from an idle, empty FIFO.
        r_valid = 1; r_data = 32'h99;
        tick(); chk("orph_no_strobe", {31'b0, s_irsp | s_drsp}, 32'h0);
        r_valid = 0;
        tick(); chk("orph_flag", {31'b0, s_orph}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
